// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the flash read arbiter: FSM states, requester id,
// word geometry and the default per-byte wait-state count.
package flash_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    GAP    = 2'd2,
    RESP   = 2'd3
  } state_t;

  localparam int BYTES_PER_WORD    = 4;
  localparam int DEFAULT_READ_WAIT = 5;

  typedef logic req_id_t;

  function automatic logic [1:0] id_onehot(input req_id_t id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/flash_read_arbiter_if.sv
// Requester-side handshake bundle: two read request channels and the shared
// response path. master = requester pair, slave = arbiter.
interface flash_read_arbiter_if #(
  parameter int ADDR_W = 23
);

  logic [1:0]        rq_valid;
  logic [ADDR_W-3:0] rq_addr0;
  logic [ADDR_W-3:0] rq_addr1;
  logic [1:0]        rq_ready;
  logic [1:0]        rsp_valid;
  logic [31:0]       rsp_data;

  modport master (
    output rq_valid, rq_addr0, rq_addr1,
    input  rq_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  rq_valid, rq_addr0, rq_addr1,
    output rq_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/flash_rr_arb.sv
// Two-input grant logic with the last_grant register (round-robin by default).
// Define FLASH_ARB_FIXED_PRIO_EN to make req0 always win when both are valid.
module flash_rr_arb
  import flash_arb_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic [1:0] req_valid,
  input  logic      accept,
  output logic      grant_valid,
  output req_id_t   grant_id
);

  assign grant_valid = |req_valid;

`ifdef FLASH_ARB_FIXED_PRIO_EN
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst_n, accept};

  always_comb begin
    grant_id = req_valid[0] ? 1'b0 : 1'b1;
  end
`else
  // Starts at 1 so req0 wins the first contended grant.
  req_id_t last_grant_reg;

  always_comb begin
    grant_id = 1'b0;
    case (req_valid)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_grant_reg;
      default: grant_id = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= 1'b1;
    end else if (accept) begin
      last_grant_reg <= grant_id;
    end
  end
`endif

endmodule

// File: rtl/flash_read_arbiter.sv
// Shares an 8-bit NOR flash between two readers; each accepted request becomes four
// timed byte reads packed little-endian into one word. Build option: FLASH_ARB_FIXED_PRIO_EN.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W    = 23,
  parameter int READ_WAIT = DEFAULT_READ_WAIT
) (
  input  logic                 clk_clk,
  input  logic                 reset_reset_n,
  flash_read_arbiter_if.slave  rq_if,
  output logic                 busy,
  output logic [ADDR_W-1:0]    fl_addr,
  input  logic [7:0]           fl_dq,
  output logic                 fl_ce_n,
  output logic                 fl_oe_n,
  output logic                 fl_we_n
);

  localparam int BIDX_W = $clog2(BYTES_PER_WORD);
  localparam int CNT_W  = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [BIDX_W-1:0] LAST_BYTE  = BIDX_W'(BYTES_PER_WORD - 1);

  state_t                            state_reg;
  logic [ADDR_W-3:0]                 word_addr_reg;
  req_id_t                           grant_reg;
  logic [BIDX_W-1:0]                 byte_idx_reg;
  logic [CNT_W-1:0]                  wait_cnt_reg;
  logic [BYTES_PER_WORD-2:0][7:0]    lane_reg;

  logic        grant_valid;
  req_id_t     grant_id;
  logic        accept;
  logic [1:0]  grant_onehot;
  logic [ADDR_W-3:0] sel_addr;

  flash_rr_arb u_arb (
    .clk         (clk_clk),
    .rst_n       (reset_reset_n),
    .req_valid   (rq_if.rq_valid),
    .accept      (accept),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_ready
    assign grant_onehot[gi] = grant_valid && (grant_id == req_id_t'(gi));
  end

  assign accept         = (state_reg == IDLE) && grant_valid;
  assign rq_if.rq_ready = (reset_reset_n && state_reg == IDLE) ? grant_onehot : 2'b00;
  assign sel_addr       = grant_id ? rq_if.rq_addr1 : rq_if.rq_addr0;
  assign fl_we_n        = 1'b1;

  // Pin controls are updated on the same edge as the state so they leave flops directly.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg       <= IDLE;
      word_addr_reg   <= '0;
      grant_reg       <= 1'b0;
      byte_idx_reg    <= '0;
      wait_cnt_reg    <= '0;
      lane_reg        <= '0;
      fl_addr         <= '0;
      fl_ce_n         <= 1'b1;
      fl_oe_n         <= 1'b1;
      busy            <= 1'b0;
      rq_if.rsp_valid <= 2'b00;
      rq_if.rsp_data  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            word_addr_reg <= sel_addr;
            grant_reg     <= grant_id;
            byte_idx_reg  <= '0;
            wait_cnt_reg  <= CNT_RELOAD;
            fl_addr       <= {sel_addr, BIDX_W'(0)};
            fl_ce_n       <= 1'b0;
            fl_oe_n       <= 1'b0;
            busy          <= 1'b1;
            state_reg     <= ACCESS;
          end
        end
        ACCESS: begin
          if (wait_cnt_reg == '0) begin
            for (int i = 0; i < BYTES_PER_WORD - 1; i++) begin
              if (byte_idx_reg == BIDX_W'(i)) begin
                lane_reg[i] <= fl_dq;
              end
            end
            fl_ce_n <= 1'b1;
            fl_oe_n <= 1'b1;
            if (byte_idx_reg == LAST_BYTE) begin
              // Final byte goes straight to the output so rsp_data only moves at RESP.
              rq_if.rsp_data  <= {fl_dq, lane_reg};
              rq_if.rsp_valid <= id_onehot(grant_reg);
              state_reg       <= RESP;
            end else begin
              state_reg <= GAP;
            end
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
        GAP: begin
          byte_idx_reg <= byte_idx_reg + 1'b1;
          wait_cnt_reg <= CNT_RELOAD;
          fl_addr      <= {word_addr_reg, byte_idx_reg + 1'b1};
          fl_ce_n      <= 1'b0;
          fl_oe_n      <= 1'b0;
          state_reg    <= ACCESS;
        end
        RESP: begin
          rq_if.rsp_valid <= 2'b00;
          busy            <= 1'b0;
          state_reg       <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
Shares the board's 8-bit parallel NOR flash between two read requesters: req0, the Nios-side configuration path, and req1, the accelerator weight fetcher. The block arbitrates round-robin and assembles four byte reads into one 32-bit little-endian word. It sequences CE_N/OE_N/address with programmable wait states and sits between the requesters and the flash pins (FL_ADDR, FL_DQ, FL_CE_N, FL_OE_N, FL_WE_N).

Parameters:
ADDR_W, 23, flash byte-address width; the word address is ADDR_W-2 bits.
READ_WAIT, 5, cycles each byte access holds CE_N/OE_N low (min 1; 5 = 100 ns at 50 MHz).

Ports:
clk_clk  in  1  system clock (soc clock domain)
reset_reset_n  in  1  asynchronous active-low reset
rq_valid  in  2  per-requester read request ([0]=req0, [1]=req1)
rq_addr0  in  ADDR_W-2  req0 word address
rq_addr1  in  ADDR_W-2  req1 word address
rq_ready  out  2  one-hot accept; at most one bit high
rsp_valid  out  2  one-cycle response pulse to the requester that was served
rsp_data  out  32  assembled word; byte0 in [7:0]
busy  out  1  high whenever state is not IDLE
fl_addr  out  ADDR_W  flash byte address
fl_dq  in  8  flash read data
fl_ce_n  out  1  flash chip enable
fl_oe_n  out  1  flash output enable
fl_we_n  out  1  held at 1; this block never writes

Behaviour:
- Clock is clk_clk. Reset is reset_reset_n, asynchronous and active-low.
- Reset values: state IDLE, fl_ce_n=1, fl_oe_n=1, fl_we_n=1, fl_addr=0, rsp_valid=0, rsp_data=0, busy=0, last_grant=1 (so req0 wins first). rq_ready is forced to 0 while reset is asserted.
- States: IDLE, ACCESS, GAP, RESP.
- IDLE:
  - rq_ready is combinational: it is high for the granted requester when that requester's rq_valid is high.
  - Grant rule: if only one requester is valid, it wins. If both are valid, the one not equal to last_grant wins.
  - On accept in cycle t: latch the word address and the grant id, update last_grant, set byte_idx=0, set the wait counter to READ_WAIT-1, and go to ACCESS.
- ACCESS:
  - fl_ce_n=0, fl_oe_n=0, fl_addr={word_addr, byte_idx}.
  - The counter decrements each cycle. On the cycle the counter is 0, fl_dq is registered into rsp_data lane byte_idx.
  - After that cycle: if byte_idx==3, go to RESP; otherwise go to GAP.
- GAP: one cycle with fl_ce_n=1 and fl_oe_n=1. byte_idx increments, the counter reloads to READ_WAIT-1, and the state returns to ACCESS.
- RESP:
  - rsp_valid[grant]=1 for exactly one cycle; rsp_data is stable from this cycle until the next RESP.
  - There is no backpressure: requesters must sink the pulse.
  - The next state is IDLE, so a new accept is possible at the earliest one cycle after RESP.
- Latency: accept at cycle t gives rsp_valid at t+4*READ_WAIT+4 (t+24 with default parameters). Throughput is one word per 4*READ_WAIT+5 cycles.
- rq_valid changes outside IDLE are ignored. A requester holds rq_valid and rq_addr until rq_ready is seen.
- If the served requester drops rq_valid mid-read, the read still completes and the response is still pulsed.
- Reset asserted mid-operation: the read is aborted immediately, flash controls go inactive, and no response is issued.
- fl_addr and the flash controls are registered outputs, so they are glitch-free at the pins.

Optional Feature:
FLASH_ARB_FIXED_PRIO_EN
- Defined: req0 always wins when both requesters are valid, and last_grant is unused. This lets the CPU preempt bulk weight streaming between words.
- Undefined: round-robin as specified above.

Decomposition:
- Package flash_arb_pkg holds:
  - the state enum (IDLE/ACCESS/GAP/RESP);
  - BYTES_PER_WORD=4;
  - the requester-id typedef (1 bit);
  - the default READ_WAIT constant.
- One sub-module, flash_rr_arb: two-input grant logic plus the last_grant register. It also contains the FLASH_ARB_FIXED_PRIO_EN switch.

Test Plan:
- Single read: req1 valid with addr=0x000010, flash model returns byte = low 8 bits of the byte address (0x40..0x43) -> rq_ready[1] at t, fl_addr steps 0x40..0x43, rsp_valid[1] at t+24 with rsp_data=0x43424140.
- Both requesters held valid continuously -> grants alternate 0,1,0,1; no requester is starved; rq_ready is never high on both bits. With FLASH_ARB_FIXED_PRIO_EN defined -> only req0 is ever granted.
- Pin timing with READ_WAIT=1 -> per word, CE/OE low 1 cycle, high 1 cycle, repeated 4 times; rsp_valid at t+8; fl_we_n is always 1.
- Reset pulsed during byte 2 of a read -> fl_ce_n and fl_oe_n go to 1 asynchronously; no rsp_valid; the next request after reset release is granted to req0 and completes normally.
- Back-to-back req0 reads of addr 0 and addr 1 -> second accept occurs exactly 1 cycle after the first RESP; responses are in order with the correct data; busy is low only in IDLE cycles.
